// File: rtl/serial_cfg_rx.sv
// serial_cfg_rx: receiver for the GPIO bit-serial config protocol (sync, LSB-first shift, word commit).
// Define SERIAL_CFG_RX_SDO_EN to add the sdo daisy-chain readback output.
module serial_cfg_rx #(
  parameter int                WIDTH       = 32,
  parameter int                SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0]  RESET_VALUE = '0,
  localparam int               CW          = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sdata,
  input  logic             sclk,
  input  logic             sel,
  output logic [WIDTH-1:0] data_out,
  output logic             update,
  output logic [CW-1:0]    bit_cnt,
  output logic             busy
`ifdef SERIAL_CFG_RX_SDO_EN
  ,
  output logic             sdo
`endif
);

  typedef enum logic {IDLE, SHIFT} state_t;

  logic [SYNC_STAGES-1:0] sdata_sync_q, sdata_sync_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic                   sclk_prev_q, sclk_prev_d;
  logic [WIDTH-1:0]       shreg_q, shreg_d;
  logic [WIDTH-1:0]       data_out_q, data_out_d;
  logic [WIDTH-1:0]       shifted;
  logic [CW-1:0]          bit_cnt_q, bit_cnt_d;
  logic                   update_q, update_d;
  state_t                 state_q, state_d;
  logic                   sdata_s, sclk_rise, accept, last;
`ifdef SERIAL_CFG_RX_SDO_EN
  logic                   sdo_q, sdo_d;
  logic                   reload_q, reload_d;
`endif

  // Both lines share the same chain depth so sdata stays aligned with sclk.
  assign sdata_s   = sdata_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_sync_q[SYNC_STAGES-1] & ~sclk_prev_q;
  assign accept    = sclk_rise & sel;
  assign last      = (bit_cnt_q == CW'(WIDTH-1));

  always_comb begin
    shifted              = shreg_q >> 1;
    shifted[WIDTH-1]     = sdata_s;

    sdata_sync_d = {sdata_sync_q[SYNC_STAGES-2:0], sdata};
    sclk_sync_d  = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
    sclk_prev_d  = sclk_sync_q[SYNC_STAGES-1];
    shreg_d      = shreg_q;
    data_out_d   = data_out_q;
    bit_cnt_d    = bit_cnt_q;
    update_d     = 1'b0;
    state_d      = state_q;
`ifdef SERIAL_CFG_RX_SDO_EN
    sdo_d        = sdo_q;
    reload_d     = 1'b0;
    // Next word shifts out the word just committed.
    if (reload_q) shreg_d = data_out_q;
`endif

    if (accept) begin
      shreg_d = shifted;
`ifdef SERIAL_CFG_RX_SDO_EN
      sdo_d   = shreg_q[0];
`endif
      if (last) begin
        data_out_d = shifted;
        update_d   = 1'b1;
        bit_cnt_d  = '0;
        state_d    = IDLE;
`ifdef SERIAL_CFG_RX_SDO_EN
        reload_d   = 1'b1;
`endif
      end else begin
        bit_cnt_d  = bit_cnt_q + 1'b1;
        state_d    = SHIFT;
      end
    end else if (!sel) begin
      // Deselect mid-word discards the partial word; also wins over a coincident edge.
      bit_cnt_d = '0;
      state_d   = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sdata_sync_q <= '0;
      sclk_sync_q  <= '0;
      sclk_prev_q  <= 1'b0;
      shreg_q      <= '0;
      data_out_q   <= RESET_VALUE;
      bit_cnt_q    <= '0;
      update_q     <= 1'b0;
      state_q      <= IDLE;
`ifdef SERIAL_CFG_RX_SDO_EN
      sdo_q        <= 1'b0;
      reload_q     <= 1'b0;
`endif
    end else begin
      sdata_sync_q <= sdata_sync_d;
      sclk_sync_q  <= sclk_sync_d;
      sclk_prev_q  <= sclk_prev_d;
      shreg_q      <= shreg_d;
      data_out_q   <= data_out_d;
      bit_cnt_q    <= bit_cnt_d;
      update_q     <= update_d;
      state_q      <= state_d;
`ifdef SERIAL_CFG_RX_SDO_EN
      sdo_q        <= sdo_d;
      reload_q     <= reload_d;
`endif
    end
  end

  assign data_out = data_out_q;
  assign update   = update_q;
  assign bit_cnt  = bit_cnt_q;
  assign busy     = (state_q == SHIFT);
`ifdef SERIAL_CFG_RX_SDO_EN
  assign sdo      = sdo_q;
`endif

endmodule

// File: tb/tb_serial_cfg_rx.sv
// Bench for serial_cfg_rx: three widths (32, 256, 1) share sdata/sclk, each with its own sel.
// A word-level model predicts every output each cycle; literal checks pin the model.
module tb_serial_cfg_rx;
  localparam int S  = 2;
  localparam int NI = 3;
  localparam logic [31:0]  RV32  = 32'hA5A5_0001;
  localparam logic [255:0] RV256 = {8{32'hC3C3_3C3C}};
  localparam logic [0:0]   RV1   = 1'b1;

  logic clk = 1'b0, rst = 1'b0, sdata = 1'b0, sclk = 1'b0;
  logic sel32 = 1'b0, sel256 = 1'b0, sel1 = 1'b0;
  logic [31:0]  do32;
  logic [255:0] do256;
  logic [0:0]   do1;
  logic up32, up256, up1, bz32, bz256, bz1;
  logic [5:0] bc32;
  logic [8:0] bc256;
  logic [0:0] bc1;
`ifdef SERIAL_CFG_RX_SDO_EN
  logic sdo32, sdo256, sdo1;
`endif

  serial_cfg_rx #(.WIDTH(32), .SYNC_STAGES(S), .RESET_VALUE(RV32)) u32 (
    .clk(clk), .rst(rst), .sdata(sdata), .sclk(sclk), .sel(sel32),
    .data_out(do32), .update(up32), .bit_cnt(bc32), .busy(bz32)
`ifdef SERIAL_CFG_RX_SDO_EN
    , .sdo(sdo32)
`endif
  );
  serial_cfg_rx #(.WIDTH(256), .SYNC_STAGES(S), .RESET_VALUE(RV256)) u256 (
    .clk(clk), .rst(rst), .sdata(sdata), .sclk(sclk), .sel(sel256),
    .data_out(do256), .update(up256), .bit_cnt(bc256), .busy(bz256)
`ifdef SERIAL_CFG_RX_SDO_EN
    , .sdo(sdo256)
`endif
  );
  serial_cfg_rx #(.WIDTH(1), .SYNC_STAGES(S), .RESET_VALUE(RV1)) u1 (
    .clk(clk), .rst(rst), .sdata(sdata), .sclk(sclk), .sel(sel1),
    .data_out(do1), .update(up1), .bit_cnt(bc1), .busy(bz1)
`ifdef SERIAL_CFG_RX_SDO_EN
    , .sdo(sdo1)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  // model state per instance
  logic [255:0] m_do [NI];
  logic [255:0] m_sh [NI];
  int           m_cnt [NI];
  bit           m_up [NI], m_sdo [NI], m_sh_ok [NI], m_sdo_ok [NI], m_reload [NI];
  int           upcnt [NI];
  // stimulus history, indexed by cycle mod 16
  bit hs [16], hd [16], hr [16];
  bit hsel [NI][16];

  function automatic int wid(input int i);
    case (i) 0: wid = 32; 1: wid = 256; default: wid = 1; endcase
  endfunction
  function automatic logic [255:0] rv(input int i);
    case (i) 0: rv = {224'b0, RV32}; 1: rv = RV256; default: rv = {255'b0, RV1}; endcase
  endfunction
  function automatic logic [255:0] d_do(input int i);
    case (i) 0: d_do = {224'b0, do32}; 1: d_do = do256; default: d_do = {255'b0, do1}; endcase
  endfunction
  function automatic logic d_up(input int i);
    case (i) 0: d_up = up32; 1: d_up = up256; default: d_up = up1; endcase
  endfunction
  function automatic logic d_bz(input int i);
    case (i) 0: d_bz = bz32; 1: d_bz = bz256; default: d_bz = bz1; endcase
  endfunction
  function automatic logic [8:0] d_bc(input int i);
    case (i) 0: d_bc = {3'b0, bc32}; 1: d_bc = bc256; default: d_bc = {8'b0, bc1}; endcase
  endfunction
  function automatic logic d_sel(input int i);
    case (i) 0: d_sel = sel32; 1: d_sel = sel256; default: d_sel = sel1; endcase
  endfunction
`ifdef SERIAL_CFG_RX_SDO_EN
  function automatic logic d_sdo(input int i);
    case (i) 0: d_sdo = sdo32; 1: d_sdo = sdo256; default: d_sdo = sdo1; endcase
  endfunction
`endif

  task automatic cmp(input string nm, input int i, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[inst %0d] got %h want %h", nm, i, act, exp);
    end
  endtask

  task automatic model_reset(input int i);
    m_do[i] = rv(i); m_sh[i] = '0; m_cnt[i] = 0; m_up[i] = 0;
    m_sdo[i] = 0; m_sh_ok[i] = 1; m_sdo_ok[i] = 1; m_reload[i] = 0;
  endtask

  // One clk edge k: sclk rise seen S+1 cycles after it was driven; sel is synchronous.
  task automatic model_step(input int i, input int k);
    bit rise, b, s;
    int w;
    w    = wid(i);
    rise = hs[(k-S-1) & 15] && !hs[(k-S-2) & 15];
    b    = hd[(k-S-1) & 15];
    s    = hsel[i][(k-1) & 15];
    m_up[i] = 0;
    if (m_reload[i]) begin m_sh[i] = m_do[i]; m_sh_ok[i] = 1; m_reload[i] = 0; end
    if (rise && s) begin
      m_sdo[i] = m_sh[i][0]; m_sdo_ok[i] = m_sh_ok[i];
      m_sh[i] = m_sh[i] >> 1;
      m_sh[i][w-1] = b;
      m_cnt[i]++;
      if (m_cnt[i] == w) begin
        m_do[i] = m_sh[i]; m_up[i] = 1; m_cnt[i] = 0; upcnt[i]++;
`ifdef SERIAL_CFG_RX_SDO_EN
        m_reload[i] = 1;
`endif
      end
    end else if (!s) begin
      if (m_cnt[i] != 0) m_sh_ok[i] = 0;
      m_cnt[i] = 0;
    end
  endtask

  // compare process
  initial begin
    int k;
    k = 0;
    for (int i = 0; i < NI; i++) begin model_reset(i); upcnt[i] = 0; end
    forever begin
      @(posedge clk); #3;
      k++;
      hs[k & 15] = sclk; hd[k & 15] = sdata; hr[k & 15] = rst;
      for (int i = 0; i < NI; i++) hsel[i][k & 15] = d_sel(i);
      if (!rst) for (int d = 0; d <= S + 2; d++) begin hs[(k-d) & 15] = 0; hd[(k-d) & 15] = 0; end
      for (int i = 0; i < NI; i++) begin
        if (!rst) model_reset(i);
        else if (hr[(k-1) & 15]) model_step(i, k);
        cmp("data_out", i, d_do(i), m_do[i]);
        cmp("update", i, 256'(d_up(i)), 256'(m_up[i]));
        cmp("bit_cnt", i, 256'(d_bc(i)), 256'(m_cnt[i]));
        cmp("busy", i, 256'(d_bz(i)), 256'(m_cnt[i] != 0));
`ifdef SERIAL_CFG_RX_SDO_EN
        if (m_sdo_ok[i]) cmp("sdo", i, 256'(d_sdo(i)), 256'(m_sdo[i]));
`endif
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input bit b);
    sdata = b; tick($urandom_range(2, 3));
    sclk  = 1; tick($urandom_range(2, 3));
    sclk  = 0; tick($urandom_range(2, 3));
  endtask

  task automatic send_word(input logic [255:0] w, input int n);
    for (int j = 0; j < n; j++) send_bit(w[j]);
  endtask

  // stimulus
  initial begin
    logic [255:0] wa, wb, got;
    logic [31:0] r;
    wa  = {{8{16'h0000}}, {8{16'hFFFF}}};
    wb  = {16{16'h1111}};
    got = '0;

    // 1: reset with sclk toggling, release with sclk high and nothing selected
    #1;
    for (int j = 0; j < 5; j++) begin sclk = 1; tick(1); sclk = 0; tick(1); end
    sclk = 1; tick(1);
    cmp("rst_data", 0, {224'b0, do32}, {224'b0, 32'hA5A5_0001});
    cmp("rst_update", 0, 256'(up32), 256'(0));
    rst = 1; tick(6);
    cmp("rel_bitcnt", 0, 256'(bc32), 256'(0));
    sclk = 0; tick(3);

    // 2: word 10, check commit latency
    sel32 = 1; sel256 = 1; sel1 = 1;
    send_word(256'h0000000A, 31);
    sdata = 0; tick(2); sclk = 1;
    tick(1); cmp("lat_e1", 0, 256'(up32), 256'(0));
    tick(1); cmp("lat_e2", 0, 256'(up32), 256'(0));
             cmp("hold_before", 0, 256'(do32), 256'(32'hA5A5_0001));
    tick(1); cmp("lat_e3", 0, 256'(up32), 256'(1));
             cmp("word_0a", 0, 256'(do32), 256'(32'h0000000A));
    tick(1); cmp("pulse_1cyc", 0, 256'(up32), 256'(0));
    sclk = 0; tick(3);
    cmp("upcnt_t2", 0, 256'(upcnt[0]), 256'(1));

    // 3: deselected word ignored
    sel32 = 0; sel256 = 0; sel1 = 0;
    send_word(256'hFFFFFFFF, 32);
    cmp("desel_data", 0, 256'(do32), 256'(32'h0000000A));
    cmp("desel_upcnt", 0, 256'(upcnt[0]), 256'(1));

    // 4: abort mid-word, then full word; then sel drop coincident with last edge
    sel32 = 1; sel1 = 1;
    r = $urandom;
    send_word(256'(r), 16);
    sel32 = 0; tick(5); sel32 = 1;
    send_word(256'h12345678, 32);
    cmp("abort_word", 0, 256'(do32), 256'(32'h12345678));
    cmp("abort_upcnt", 0, 256'(upcnt[0]), 256'(2));
    r = $urandom;
    send_word(256'(r), 31);
    sdata = r[31]; tick(2); sclk = 1; tick(S);
    sel32 = 0; tick(1);
    cmp("coinc_update", 0, 256'(up32), 256'(0));
    cmp("coinc_bitcnt", 0, 256'(bc32), 256'(0));
    tick(1); sclk = 0; tick(3);
    cmp("coinc_data", 0, 256'(do32), 256'(32'h12345678));
    cmp("coinc_upcnt", 0, 256'(upcnt[0]), 256'(2));

    // 5: reset mid-word, then a clean word
    sel32 = 1;
    r = $urandom;
    send_word(256'(r), 20);
    rst = 0; tick(2);
    cmp("midrst_data", 0, 256'(do32), 256'(32'hA5A5_0001));
    cmp("midrst_bitcnt", 0, 256'(bc32), 256'(0));
    rst = 1; tick(3);
    send_word(256'hDEADBEEF, 32);
    cmp("after_rst", 0, 256'(do32), 256'(32'hDEADBEEF));

    // 6: two back-to-back 256-bit words
    sel32 = 0; sel1 = 0; sel256 = 1;
    send_word(wa, 256);
    cmp("w256_a", 1, do256, wa);
    cmp("w256_upcnt_a", 1, 256'(upcnt[1]), 256'(1));
    for (int j = 0; j < 256; j++) begin
      send_bit(wb[j]);
`ifdef SERIAL_CFG_RX_SDO_EN
      got[j] = sdo256;
`endif
    end
    cmp("w256_b", 1, do256, wb);
    cmp("w256_upcnt_b", 1, 256'(upcnt[1]), 256'(2));
`ifdef SERIAL_CFG_RX_SDO_EN
    cmp("sdo_replay", 1, got, wa);
`endif

    // 7: random bits with random sel toggling on every instance
    sel32 = 1; sel1 = 1;
    for (int j = 0; j < 150; j++) begin
      if ($urandom_range(0, 15) == 0) sel32  = ~sel32;
      if ($urandom_range(0, 15) == 0) sel256 = ~sel256;
      if ($urandom_range(0, 15) == 0) sel1   = ~sel1;
      send_bit(1'($urandom_range(0, 1)));
    end
    tick(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
